// File: rtl/local_pred_pkg.sv
// Shared types and helpers for the local pattern history table.
package local_pred_pkg;

  localparam int LP_HIST_W = 10;

  typedef logic [1:0] ctr_t;

  localparam ctr_t STRONG_NT = 2'b00;
  localparam ctr_t WEAK_NT   = 2'b01;
  localparam ctr_t WEAK_T    = 2'b10;
  localparam ctr_t STRONG_T  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [LP_HIST_W-1:0] index;
    logic                 pred;
  } lp_pipe_t;

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != STRONG_T) nxt = ctr + 2'b01;
    end else begin
      if (ctr != STRONG_NT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lp_delay_pipe.sv
// Lookup-to-resolve delay line: carries {valid, index, predicted bit} DEPTH cycles.
module lp_delay_pipe
  import local_pred_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  lp_pipe_t d,
  output lp_pipe_t q
);

  lp_pipe_t stage [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/local_prediction.sv
// Local-side PHT: registered lookup of 2-bit counters, delayed training, mispredict flag.
// Optional LP_BYPASS_EN: forward the same-cycle counter update into a colliding lookup.
module local_prediction
  import local_pred_pkg::*;
#(
  parameter int   HIST_W       = LP_HIST_W,
  parameter int   UPDATE_DELAY = 2,
  parameter ctr_t CTR_INIT     = WEAK_NT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hist_valid,
  input  logic [HIST_W-1:0] hist_in,
  input  logic              taken_valid,
  input  logic              taken,
  output logic              predict,
  output logic              predict_valid,
  output logic              mispredict
);

  localparam int DEPTH = 1 << HIST_W;

  ctr_t              ctr [DEPTH];
  lp_pipe_t          pipe_in;
  lp_pipe_t          tail;
  logic [HIST_W-1:0] wr_index;
  logic              do_update;
  ctr_t              upd_ctr;
  logic              rd_bit;

  assign wr_index  = HIST_W'(tail.index);
  assign do_update = tail.valid & taken_valid;
  assign upd_ctr   = sat_update(ctr[wr_index], taken);

`ifdef LP_BYPASS_EN
  assign rd_bit = (do_update && (wr_index == hist_in)) ? upd_ctr[1] : ctr[hist_in][1];
`else
  assign rd_bit = ctr[hist_in][1];
`endif

  // The stored prediction is whatever was actually reported, forwarded or not.
  assign pipe_in = '{valid: hist_valid, index: LP_HIST_W'(hist_in), pred: rd_bit};

  lp_delay_pipe #(
    .DEPTH (UPDATE_DELAY)
  ) u_pipe (
    .clock (clock),
    .reset (reset),
    .d     (pipe_in),
    .q     (tail)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_INIT;
    end else if (do_update) begin
      ctr[wr_index] <= upd_ctr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      predict       <= 1'b0;
      predict_valid <= 1'b0;
      mispredict    <= 1'b0;
    end else begin
      predict       <= hist_valid & rd_bit;
      predict_valid <= hist_valid;
      mispredict    <= do_update & (taken ^ tail.pred);
    end
  end

endmodule

// File: tb/tb_local_prediction.sv
// Self-checking bench for local_prediction (HIST_W=10, UPDATE_DELAY=2); honours LP_BYPASS_EN.
module tb_local_prediction;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hist_valid = 1'b0;
  logic [9:0] hist_in = '0;
  logic       taken_valid = 1'b0;
  logic       taken = 1'b0;
  logic       predict;
  logic       predict_valid;
  logic       mispredict;

  typedef struct {
    logic pv;
    logic p;
    logic mp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // reference model: counters plus a 2-entry delay line (index 1 is the tail)
  logic [1:0] m_ctr [1024];
  logic       m_v [2];
  logic [9:0] m_i [2];
  logic       m_p [2];
  logic       obs_p;
  logic       obs_mp;

  always #5 clock = ~clock;

  local_prediction #(
    .HIST_W       (10),
    .UPDATE_DELAY (2),
    .CTR_INIT     (2'b01)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .hist_valid    (hist_valid),
    .hist_in       (hist_in),
    .taken_valid   (taken_valid),
    .taken         (taken),
    .predict       (predict),
    .predict_valid (predict_valid),
    .mispredict    (mispredict)
  );

  function automatic logic [1:0] m_sat(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_ctr[i] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0;
      m_i[i] = '0;
      m_p[i] = 1'b0;
    end
  endtask

  // Drive one cycle at the falling edge, predict outputs, check after the next rising edge.
  task automatic cycle(input logic hv, input logic [9:0] hi, input logic tv, input logic tk,
                       input string tag);
    exp_t       e;
    logic       upd;
    logic [1:0] nc;
    logic       rd;
    hist_valid  = hv;
    hist_in     = hi;
    taken_valid = tv;
    taken       = tk;
    upd = m_v[1] && tv;
    nc  = m_sat(m_ctr[m_i[1]], tk);
    rd  = m_ctr[hi][1];
`ifdef LP_BYPASS_EN
    if (upd && (m_i[1] == hi)) rd = nc[1];
`endif
    e.pv = hv;
    e.p  = hv & rd;
    e.mp = upd && (tk != m_p[1]);
    sb.push_back(e);
    if (upd) m_ctr[m_i[1]] = nc;
    m_v[1] = m_v[0]; m_i[1] = m_i[0]; m_p[1] = m_p[0];
    m_v[0] = hv;     m_i[0] = hi;     m_p[0] = rd;
    @(posedge clock);
    @(negedge clock);
    e = sb.pop_front();
    if (predict_valid !== e.pv)
      $display("FAIL %s predict_valid got %b want %b", tag, predict_valid, e.pv);
    else n_pass++;
    n_checks++;
    if (predict !== e.p)
      $display("FAIL %s predict got %b want %b", tag, predict, e.p);
    else n_pass++;
    n_checks++;
    if (mispredict !== e.mp)
      $display("FAIL %s mispredict got %b want %b", tag, mispredict, e.mp);
    else n_pass++;
    n_checks++;
    obs_p  = predict;
    obs_mp = mispredict;
  endtask

  // Lookup, one idle cycle, then resolve; returns the prediction and the mispredict pulse.
  task automatic lookup_resolve(input logic [9:0] idx, input logic tk, input string tag,
                                output logic p, output logic m);
    cycle(1'b1, idx, 1'b0, 1'b0, tag);
    p = obs_p;
    cycle(1'b0, '0, 1'b0, 1'b0, tag);
    cycle(1'b0, '0, 1'b1, tk, tag);
    m = obs_mp;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    if (predict !== 1'b0) $display("FAIL reset_predict got %b want 0", predict);
    else n_pass++;
    n_checks++;
    if (predict_valid !== 1'b0) $display("FAIL reset_pvalid got %b want 0", predict_valid);
    else n_pass++;
    n_checks++;
    if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %b want 0", mispredict);
    else n_pass++;
    n_checks++;
    reset = 1'b1;
  endtask

  task automatic test_first_lookup();
    cycle(1'b1, 10'h3FF, 1'b0, 1'b0, "first_lookup");
    if (obs_p !== 1'b0) $display("FAIL first_lookup_pred got %b want 0", obs_p);
    else n_pass++;
    n_checks++;
    cycle(1'b0, '0, 1'b0, 1'b0, "first_idle");
    cycle(1'b0, '0, 1'b0, 1'b0, "first_idle");
  endtask

  task automatic test_train();
    logic [2:0] exp_p = 3'b110;
    logic [2:0] exp_m = 3'b001;
    logic p, m;
    for (int k = 0; k < 3; k++) begin
      lookup_resolve(10'h155, 1'b1, "train", p, m);
      if (p !== exp_p[k]) $display("FAIL train_pred[%0d] got %b want %b", k, p, exp_p[k]);
      else n_pass++;
      n_checks++;
      if (m !== exp_m[k]) $display("FAIL train_misp[%0d] got %b want %b", k, m, exp_m[k]);
      else n_pass++;
      n_checks++;
    end
  endtask

  task automatic test_saturate();
    logic p, m;
    for (int k = 0; k < 5; k++) begin
      lookup_resolve(10'h155, 1'b1, "sat_taken", p, m);
      if (m !== 1'b0) $display("FAIL sat_misp[%0d] got %b want 0", k, m);
      else n_pass++;
      n_checks++;
    end
    lookup_resolve(10'h155, 1'b0, "sat_not_taken", p, m);
    if (m !== 1'b1) $display("FAIL sat_nt_misp got %b want 1", m);
    else n_pass++;
    n_checks++;
    lookup_resolve(10'h155, 1'b1, "sat_after", p, m);
    if (p !== 1'b1) $display("FAIL sat_after_pred got %b want 1", p);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_drop();
    logic p, m;
    cycle(1'b1, 10'h02A, 1'b0, 1'b0, "drop_lookup");
    cycle(1'b0, '0, 1'b0, 1'b0, "drop_idle");
    cycle(1'b0, '0, 1'b0, 1'b1, "drop_tail_no_taken");
    cycle(1'b0, '0, 1'b1, 1'b1, "drop_taken_no_tail");
    if (obs_mp !== 1'b0) $display("FAIL drop_stray_misp got %b want 0", obs_mp);
    else n_pass++;
    n_checks++;
    lookup_resolve(10'h02A, 1'b1, "drop_check", p, m);
    if (p !== 1'b0 || m !== 1'b1) $display("FAIL drop_ctr got p=%b m=%b want p=0 m=1", p, m);
    else n_pass++;
    n_checks++;
    lookup_resolve(10'h02A, 1'b0, "drop_check2", p, m);
    if (p !== 1'b1) $display("FAIL drop_ctr2 got %b want 1", p);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_collision();
    logic exp_fwd;
`ifdef LP_BYPASS_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    cycle(1'b1, 10'h010, 1'b0, 1'b0, "coll_lookup");
    cycle(1'b0, '0, 1'b0, 1'b0, "coll_idle");
    cycle(1'b1, 10'h010, 1'b1, 1'b1, "coll_same");
    if (obs_p !== exp_fwd) $display("FAIL coll_pred got %b want %b", obs_p, exp_fwd);
    else n_pass++;
    n_checks++;
    cycle(1'b0, '0, 1'b0, 1'b0, "coll_idle");
    cycle(1'b0, '0, 1'b1, 1'b1, "coll_resolve2");
    if (obs_mp !== ~exp_fwd) $display("FAIL coll_stored_pred got misp=%b want %b", obs_mp, ~exp_fwd);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid();
    logic p, m;
    lookup_resolve(10'h100, 1'b1, "rst_prep", p, m);
    lookup_resolve(10'h100, 1'b1, "rst_prep", p, m);
    cycle(1'b1, 10'h100, 1'b0, 1'b0, "rst_inflight");
    cycle(1'b1, 10'h101, 1'b0, 1'b0, "rst_inflight");
    reset = 1'b0;
    #1;
    if ({predict, predict_valid, mispredict} !== 3'b000)
      $display("FAIL rst_async_outputs got %b want 000", {predict, predict_valid, mispredict});
    else n_pass++;
    n_checks++;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b1, "rst_stale_taken");
    if (obs_mp !== 1'b0) $display("FAIL rst_stale_misp got %b want 0", obs_mp);
    else n_pass++;
    n_checks++;
    lookup_resolve(10'h100, 1'b1, "rst_ctr", p, m);
    if (p !== 1'b0 || m !== 1'b1) $display("FAIL rst_ctr got p=%b m=%b want p=0 m=1", p, m);
    else n_pass++;
    n_checks++;
    lookup_resolve(10'h101, 1'b0, "rst_ctr2", p, m);
    if (p !== 1'b0) $display("FAIL rst_ctr2 got %b want 0", p);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] pool [4];
    pool[0] = 10'h010;
    pool[1] = 10'h011;
    pool[2] = 10'h155;
    pool[3] = 10'h2AA;
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)],
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_first_lookup();
    test_train();
    test_saturate();
    test_drop();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
